// File: rtl/bus_pkg.sv
// Shared bus types for the CPU/DMA/MMU request path.
// Pure declarations: no latency or flow control of its own.
package bus_pkg;

  typedef enum logic [1:0] {
    BUS_OP_IDLE  = 2'd0,
    BUS_OP_READ  = 2'd1,
    BUS_OP_WRITE = 2'd2
  } bus_op_t;

  typedef enum logic {
    BUS_SIZE_BYTE = 1'b0,
    BUS_SIZE_WORD = 1'b1
  } bus_size_t;

  typedef enum logic {
    OWNER_CPU = 1'b0,
    OWNER_DMA = 1'b1
  } bus_owner_t;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

  typedef struct packed {
    bus_op_t     op;
    bus_size_t   size;
    logic [15:0] addr;
    logic [15:0] wdata;
  } bus_req_t;

  localparam logic [15:0] BUS_ERR_DATA = 16'hFFFF;

  function automatic logic req_present(input bus_op_t op);
    return op != BUS_OP_IDLE;
  endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Transaction watchdog: counts enabled cycles, flags the cycle in which the count reaches TIMEOUT_CYCLES.
// Expired is combinational from the count (0 cycles); no backpressure, TIMEOUT_CYCLES=0 never expires.
module bus_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CW-1:0] LIMIT = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  // Saturates so a disabled watchdog cannot wrap into a false expiry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (TIMEOUT_CYCLES != 0) && enable && (count == LIMIT);

endmodule

// File: rtl/bus_arbiter.sv
// CPU/DMA arbiter for the single MMU port: DMA priority with a starvation limit, watchdog abort.
// Grant to MMU drive 1 cycle, response pulse 1 cycle after MMU completion; requesters hold until their pulse.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned DMA_STREAK_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  bus_op_t     cpu_req_op,
  input  bus_size_t   cpu_req_size,
  input  logic [15:0] cpu_req_addr,
  input  logic [15:0] cpu_req_wdata,
  output logic        cpu_resp_valid,
  output logic [15:0] cpu_resp_rdata,
  output logic        cpu_resp_err,
  input  bus_op_t     dma_req_op,
  input  bus_size_t   dma_req_size,
  input  logic [15:0] dma_req_addr,
  input  logic [15:0] dma_req_wdata,
  output logic        dma_resp_valid,
  output logic [15:0] dma_resp_rdata,
  output logic        dma_resp_err,
  output bus_op_t     mmu_req_op,
  output bus_size_t   mmu_req_size,
  output logic [15:0] mmu_req_addr,
  output logic [15:0] mmu_req_wdata,
  input  logic        mmu_resp_valid,
  input  logic [15:0] mmu_resp_rdata,
  output logic        grant_dma
);

  localparam int unsigned SW = ($clog2(DMA_STREAK_MAX + 1) > 0) ? $clog2(DMA_STREAK_MAX + 1) : 1;
  localparam logic [SW-1:0] STREAK_MAX = SW'(DMA_STREAK_MAX);

  arb_state_t    state_q, state_d;
  bus_req_t      req_q, req_d;
  bus_owner_t    owner_q, owner_d;
  logic [15:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [SW-1:0] streak_q, streak_d;

  bus_req_t cpu_req, dma_req;
  logic     cpu_pend, dma_pend, cpu_wins;
  logic     wd_clear, wd_expired, resp_fire;

  assign cpu_req  = '{op: cpu_req_op, size: cpu_req_size, addr: cpu_req_addr, wdata: cpu_req_wdata};
  assign dma_req  = '{op: dma_req_op, size: dma_req_size, addr: dma_req_addr, wdata: dma_req_wdata};
  assign cpu_pend = req_present(cpu_req_op);
  assign dma_pend = req_present(dma_req_op);
  assign cpu_wins = cpu_pend && (!dma_pend || (streak_q == STREAK_MAX));

  bus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (wd_clear),
    .enable (state_q == ARB_BUSY),
    .expired(wd_expired)
  );

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    owner_d  = owner_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    streak_d = streak_q;
    wd_clear = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (cpu_pend || dma_pend) begin
          wd_clear = 1'b1;
          state_d  = ARB_BUSY;
          if (cpu_wins) begin
            req_d    = cpu_req;
            owner_d  = OWNER_CPU;
            streak_d = '0;
          end else begin
            req_d   = dma_req;
            owner_d = OWNER_DMA;
            // Only grants that actually make the CPU wait count toward the streak.
            if (!cpu_pend) begin
              streak_d = '0;
            end else if (streak_q != STREAK_MAX) begin
              streak_d = streak_q + SW'(1);
            end
          end
        end
      end
      ARB_BUSY: begin
        // A response in the expiry cycle still wins over the abort.
        if (mmu_resp_valid) begin
          rdata_d = mmu_resp_rdata;
          err_d   = 1'b0;
          state_d = ARB_RESP;
        end else if (wd_expired) begin
          rdata_d = BUS_ERR_DATA;
          err_d   = 1'b1;
          state_d = ARB_RESP;
        end
      end
      ARB_RESP: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ARB_IDLE;
      req_q    <= '{op: BUS_OP_IDLE, size: BUS_SIZE_BYTE, addr: 16'h0000, wdata: 16'h0000};
      owner_q  <= OWNER_CPU;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      owner_q  <= owner_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      streak_q <= streak_d;
    end
  end

  assign mmu_req_op    = (state_q == ARB_BUSY) ? req_q.op : BUS_OP_IDLE;
  assign mmu_req_size  = req_q.size;
  assign mmu_req_addr  = req_q.addr;
  assign mmu_req_wdata = req_q.wdata;

  assign resp_fire      = (state_q == ARB_RESP);
  assign cpu_resp_valid = resp_fire && (owner_q == OWNER_CPU);
  assign dma_resp_valid = resp_fire && (owner_q == OWNER_DMA);
  assign cpu_resp_rdata = cpu_resp_valid ? rdata_q : 16'h0000;
  assign dma_resp_rdata = dma_resp_valid ? rdata_q : 16'h0000;
  assign cpu_resp_err   = cpu_resp_valid && err_q;
  assign dma_resp_err   = dma_resp_valid && err_q;
  assign grant_dma      = (owner_q == OWNER_DMA);

endmodule
